// File: rtl/uc_pilha_pkg.sv
// Shared encodings for the parametrised stack-processor control unit:
// opcodes, error codes and the sequencer state set.
package uc_pilha_pkg;

   localparam int unsigned OP_PUSH   = 1;
   localparam int unsigned OP_PUSH_I = 2;
   localparam int unsigned OP_PUSH_T = 3;
   localparam int unsigned OP_POP    = 4;
   localparam int unsigned OP_ADD    = 5;
   localparam int unsigned OP_SUB    = 6;
   localparam int unsigned OP_AND    = 7;
   localparam int unsigned OP_OR     = 8;
   localparam int unsigned OP_NOT    = 9;
   localparam int unsigned OP_GOTO   = 10;
   localparam int unsigned OP_COND   = 11;
   localparam int unsigned OP_HALT   = 12;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_OVF  = 2'b01;
   localparam logic [1:0] ERR_UNF  = 2'b10;
   localparam logic [1:0] ERR_ILL  = 2'b11;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_PUSH_RD,
      S_PUSH_WR,
      S_PUSH_I,
      S_PUSH_T,
      S_POP_RD,
      S_POP_WR,
      S_A1,
      S_A2,
      S_A3,
      S_N1,
      S_N2,
      S_JUMP,
      S_HALT,
      S_ERRO
   } state_t;

   // Occupancy counter must represent 0..depth inclusive.
   function automatic int unsigned sp_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uc_pilha_sp.sv
// Stack occupancy counter: saturating push/pop with full, empty and
// at-least-two flags used by the sequencer's pre-checks.
module uc_pilha_sp
#(
   parameter int unsigned DEPTH = 16
)(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 push,
   input  logic                 pop,
   output logic [$clog2(DEPTH):0] sp,
   output logic                 full,
   output logic                 empty,
   output logic                 ge2
);
   import uc_pilha_pkg::*;

   localparam int unsigned SP_W = sp_width(DEPTH);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sp <= '0;
      end else if (push && !full) begin
         sp <= sp + SP_W'(1);
      end else if (pop && !empty) begin
         sp <= sp - SP_W'(1);
      end
   end

   assign full  = (sp == SP_W'(DEPTH));
   assign empty = (sp == '0);
   assign ge2   = (sp >= SP_W'(2));

endmodule

// File: rtl/uc_pilha_param.sv
// Parametrised stack-processor control unit: fetch/decode/execute sequencer
// driving ROM, RAM, stack and temp-register strobes, with trap and halt states.
module uc_pilha_param
#(
   parameter int unsigned OP_W   = 5,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 16
)(
   input  logic                   clock,
   input  logic                   reset,
   input  logic [OP_W+ADDR_W-1:0] inst,
   input  logic [DATA_W-1:0]      data_mem,
   input  logic                   controle_ula,
   output logic                   rom_en,
   output logic [ADDR_W-1:0]      a_rom,
   output logic                   ram_en,
   output logic                   ram_wren,
   output logic [ADDR_W-1:0]      a_ram,
   output logic                   pilha_wren,
   output logic                   pilha_rd,
   output logic [$clog2(DEPTH):0] sp,
   output logic [DATA_W-1:0]      data_pilha,
   output logic                   load_temp1,
   output logic                   load_temp2,
   output logic [OP_W-1:0]        opcode,
   output logic                   halted,
   output logic [1:0]             erro,
   output logic                   pc_wrap
);
   import uc_pilha_pkg::*;

   localparam int unsigned IW = OP_W + ADDR_W;

   state_t              state, state_n;
   logic [ADDR_W-1:0]   pc, pc_n;
   logic [IW-1:0]       ir, ir_n;
   logic [OP_W-1:0]     in_op, ir_op;
   logic [ADDR_W-1:0]   in_arg, ir_arg;

   logic                rom_en_n, ram_en_n, ram_wren_n, pilha_wren_n, pilha_rd_n;
   logic                load_temp1_n, load_temp2_n, halted_n, pc_wrap_n;
   logic [ADDR_W-1:0]   a_ram_n;
   logic [DATA_W-1:0]   data_pilha_n;
   logic [OP_W-1:0]     opcode_n;
   logic [1:0]          erro_n;
   logic                sp_push, sp_pop, sp_full, sp_empty, sp_ge2;

   assign in_op  = inst[IW-1:ADDR_W];
   assign in_arg = inst[ADDR_W-1:0];
   assign ir_op  = ir[IW-1:ADDR_W];
   assign ir_arg = ir[ADDR_W-1:0];
   assign a_rom  = pc;

   uc_pilha_sp #(.DEPTH(DEPTH)) u_sp (
      .clock (clock),
      .reset (reset),
      .push  (sp_push),
      .pop   (sp_pop),
      .sp    (sp),
      .full  (sp_full),
      .empty (sp_empty),
      .ge2   (sp_ge2)
   );

   always_comb begin
      state_n      = state;
      pc_n         = pc;
      ir_n         = ir;
      a_ram_n      = a_ram;
      data_pilha_n = data_pilha;
      opcode_n     = opcode;
      halted_n     = halted;
      erro_n       = erro;
      ram_en_n     = 1'b0;
      ram_wren_n   = 1'b0;
      pilha_wren_n = 1'b0;
      pilha_rd_n   = 1'b0;
      load_temp1_n = 1'b0;
      load_temp2_n = 1'b0;
      pc_wrap_n    = 1'b0;
      sp_push      = 1'b0;
      sp_pop       = 1'b0;

      case (state)
         // rom_en is low only in the first FETCH after reset; that cycle just arms the read.
         S_FETCH: if (rom_en) state_n = S_DECODE;
         S_DECODE: begin
            ir_n      = inst;
            opcode_n  = in_op;
            pc_n      = pc + ADDR_W'(1);
            pc_wrap_n = &pc;
            case (in_op)
               OP_W'(OP_PUSH): begin
                  if (sp_full) begin
                     state_n = S_ERRO;
                     erro_n  = ERR_OVF;
                  end else begin
                     state_n  = S_PUSH_RD;
                     ram_en_n = 1'b1;
                     a_ram_n  = in_arg;
                  end
               end
               OP_W'(OP_PUSH_I): begin
                  if (sp_full) begin
                     state_n = S_ERRO;
                     erro_n  = ERR_OVF;
                  end else begin
                     state_n      = S_PUSH_I;
                     pilha_wren_n = 1'b1;
                     data_pilha_n = DATA_W'(in_arg);
                     sp_push      = 1'b1;
                  end
               end
               // The ULA result lives in the datapath; it steers its own write mux here.
               OP_W'(OP_PUSH_T): begin
                  if (sp_full) begin
                     state_n = S_ERRO;
                     erro_n  = ERR_OVF;
                  end else begin
                     state_n      = S_PUSH_T;
                     pilha_wren_n = 1'b1;
                     sp_push      = 1'b1;
                  end
               end
               OP_W'(OP_POP): begin
                  if (sp_empty) begin
                     state_n = S_ERRO;
                     erro_n  = ERR_UNF;
                  end else begin
                     state_n    = S_POP_RD;
                     pilha_rd_n = 1'b1;
                     sp_pop     = 1'b1;
                  end
               end
               OP_W'(OP_ADD), OP_W'(OP_SUB), OP_W'(OP_AND), OP_W'(OP_OR): begin
                  if (!sp_ge2) begin
                     state_n = S_ERRO;
                     erro_n  = ERR_UNF;
                  end else begin
                     state_n      = S_A1;
                     pilha_rd_n   = 1'b1;
                     load_temp1_n = 1'b1;
                     sp_pop       = 1'b1;
                  end
               end
               OP_W'(OP_NOT): begin
                  if (sp_empty) begin
                     state_n = S_ERRO;
                     erro_n  = ERR_UNF;
                  end else begin
                     state_n      = S_N1;
                     pilha_rd_n   = 1'b1;
                     load_temp1_n = 1'b1;
                     sp_pop       = 1'b1;
                  end
               end
               OP_W'(OP_GOTO), OP_W'(OP_COND): state_n = S_JUMP;
               OP_W'(OP_HALT): begin
                  state_n  = S_HALT;
                  halted_n = 1'b1;
               end
               default: begin
                  state_n = S_ERRO;
                  erro_n  = ERR_ILL;
               end
            endcase
         end
         S_PUSH_RD: state_n = S_PUSH_WR;
         // data_mem is only valid now, so the registered stack write lands in the next FETCH.
         S_PUSH_WR: begin
            state_n      = S_FETCH;
            pilha_wren_n = 1'b1;
            data_pilha_n = data_mem;
            sp_push      = 1'b1;
         end
         S_PUSH_I: state_n = S_FETCH;
         S_PUSH_T: state_n = S_FETCH;
         S_POP_RD: begin
            state_n    = S_POP_WR;
            ram_en_n   = 1'b1;
            ram_wren_n = 1'b1;
            a_ram_n    = ir_arg;
         end
         S_POP_WR: state_n = S_FETCH;
         S_A1: begin
            state_n      = S_A2;
            pilha_rd_n   = 1'b1;
            load_temp2_n = 1'b1;
            sp_pop       = 1'b1;
         end
         S_A2: begin
            state_n      = S_A3;
            pilha_wren_n = 1'b1;
            sp_push      = 1'b1;
         end
         S_A3: state_n = S_FETCH;
         S_N1: begin
            state_n      = S_N2;
            pilha_wren_n = 1'b1;
            sp_push      = 1'b1;
         end
         S_N2: state_n = S_FETCH;
         S_JUMP: begin
            state_n = S_FETCH;
            if (ir_op != OP_W'(OP_COND) || controle_ula) pc_n = ir_arg;
         end
         S_HALT: state_n = S_HALT;
         S_ERRO: state_n = S_ERRO;
      endcase

      rom_en_n = (state_n == S_FETCH);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_FETCH;
         pc         <= '0;
         ir         <= '0;
         rom_en     <= 1'b0;
         ram_en     <= 1'b0;
         ram_wren   <= 1'b0;
         a_ram      <= '0;
         pilha_wren <= 1'b0;
         pilha_rd   <= 1'b0;
         data_pilha <= '0;
         load_temp1 <= 1'b0;
         load_temp2 <= 1'b0;
         opcode     <= '0;
         halted     <= 1'b0;
         erro       <= ERR_NONE;
         pc_wrap    <= 1'b0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         ir         <= ir_n;
         rom_en     <= rom_en_n;
         ram_en     <= ram_en_n;
         ram_wren   <= ram_wren_n;
         a_ram      <= a_ram_n;
         pilha_wren <= pilha_wren_n;
         pilha_rd   <= pilha_rd_n;
         data_pilha <= data_pilha_n;
         load_temp1 <= load_temp1_n;
         load_temp2 <= load_temp2_n;
         opcode     <= opcode_n;
         halted     <= halted_n;
         erro       <= erro_n;
         pc_wrap    <= pc_wrap_n;
      end
   end

endmodule
